// File: rtl/cpu_datapath_param.sv
// Parametrised single-issue datapath for the 8-bit, 4-op teaching ISA: register file, resettable
// data memory, execution-clock divider, sticky signed overflow, self-jump halt and nibble display tap.
module cpu_datapath_param #(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 4,
  parameter int DIV_HALF   = 1
) (
  input  logic            _CLK,
  input  logic            RESET,
  input  logic [7:0]      instruction,
  input  logic [1:0]      disp_sel,
  output logic [PC_W-1:0] PC,
  output logic            CLK_,
  output logic [3:0]      m,
  output logic [3:0]      l,
  output logic            ovf,
  output logic            halted
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_HALF - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;

  logic [CW-1:0]     div_cnt;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [1:0]        op, rs, rt, rd;
  logic [DATA_W-1:0] rs_val, rt_val, add_sum, imm_ext;
  logic [AW-1:0]     mem_addr;
  logic [PC_W-1:0]   pc_inc, pc_jump;
  logic              add_ovf, is_halt, div_wrap, commit;

  assign op = instruction[7:6];
  assign rs = instruction[5:4];
  assign rt = instruction[3:2];
  assign rd = instruction[1:0];

  assign imm_ext  = DATA_W'($signed(instruction[1:0]));
  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign add_sum  = rs_val + rt_val;
  assign add_ovf  = (rs_val[DATA_W-1] == rt_val[DATA_W-1]) &&
                    (add_sum[DATA_W-1] != rs_val[DATA_W-1]);
  // Full-width base+offset sum, then only the low address bits select the word.
  assign mem_addr = AW'(rs_val + imm_ext);

  assign pc_inc  = PC + PC_W'(1);
  assign pc_jump = pc_inc + PC_W'($signed(instruction[5:0]));
  // Reduction AND keeps an offset ending in a known 0 from ever looking like a self-jump.
  assign is_halt = &instruction[5:0];

  assign div_wrap = (div_cnt == DIV_LAST);
  assign commit   = div_wrap && CLK_;

  assign m = regs[disp_sel][7:4];
  assign l = regs[disp_sel][3:0];

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      CLK_    <= 1'b0;
      PC      <= '0;
      ovf     <= 1'b0;
      halted  <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      // NOTE: the data memory is deliberately reset (M[i]=i), so it is built from flops, not a RAM macro.
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= DATA_W'(i);
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        CLK_    <= ~CLK_;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end

      // Architectural state only moves on the CLK_ falling edge.
      if (commit && !halted) begin
        case (op)
          OP_ADD: begin
            regs[rd] <= add_sum;
            if (add_ovf) ovf <= 1'b1;
            PC <= pc_inc;
          end
          OP_LW: begin
            regs[rt] <= dmem[mem_addr];
            PC <= pc_inc;
          end
          OP_SW: begin
            dmem[mem_addr] <= rt_val;
            PC <= pc_inc;
          end
          default: begin
            if (is_halt) halted <= 1'b1;
            else         PC     <= pc_jump;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_datapath_param.sv
// Self-checking bench for cpu_datapath_param: a reference model pushes the expected post-commit
// state into a scoreboard that a monitor pops on every commit edge; a second instance covers DIV_HALF=3.
module tb_cpu_datapath_param;

  typedef struct packed {
    logic [7:0]      pc;
    logic            ovf;
    logic            halt;
    logic [3:0][7:0] r;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst = 1'b1;
  logic [7:0] ins = 8'h00;
  logic [1:0] sel = 2'd0;
  logic [7:0] pc;
  logic       clkd, ovf, halted;
  logic [3:0] m, l;

  cpu_datapath_param dut_a (
    ._CLK(clk), .RESET(rst), .instruction(ins), .disp_sel(sel),
    .PC(pc), .CLK_(clkd), .m(m), .l(l), .ovf(ovf), .halted(halted)
  );

  // Slow-divider, narrow-PC instance
  logic       rst3 = 1'b1;
  logic [7:0] ins3 = 8'h00;
  logic [1:0] sel3 = 2'd0;
  logic [2:0] pc3;
  logic       clkd3, ovf3, halt3;
  logic [3:0] m3, l3;

  cpu_datapath_param #(.DATA_W(8), .PC_W(3), .DMEM_DEPTH(4), .DIV_HALF(3)) dut_b (
    ._CLK(clk), .RESET(rst3), .instruction(ins3), .disp_sel(sel3),
    .PC(pc3), .CLK_(clkd3), .m(m3), .l(l3), .ovf(ovf3), .halted(halt3)
  );

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  logic [7:0] mr [4];
  logic [7:0] mm [4];
  logic [7:0] mpc;
  logic       movf, mhalt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mr[i] = 8'h00;
      mm[i] = 8'(i);
    end
    mpc = 8'h00; movf = 1'b0; mhalt = 1'b0;
  endtask

  task automatic model_exec(input logic [7:0] x);
    logic [7:0] a, b, s, base, off;
    logic [1:0] addr;
    if (mhalt) return;
    a    = mr[x[5:4]];
    b    = mr[x[3:2]];
    base = a + {{6{x[1]}}, x[1:0]};
    addr = base[1:0];
    case (x[7:6])
      2'b00: begin
        s = a + b;
        if (a[7] == b[7] && s[7] != a[7]) movf = 1'b1;
        mr[x[1:0]] = s;
        mpc = mpc + 8'd1;
      end
      2'b01: begin mr[x[3:2]] = mm[addr]; mpc = mpc + 8'd1; end
      2'b10: begin mm[addr] = b; mpc = mpc + 8'd1; end
      default: begin
        if (x[5:0] == 6'h3f) mhalt = 1'b1;
        else begin
          off = {{2{x[5]}}, x[5:0]};
          mpc = mpc + 8'd1 + off;
        end
      end
    endcase
  endtask

  // Scoreboard consumer: one expected state per observed commit edge.
  task automatic monitor();
    logic prev = 1'bx;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b0 && prev === 1'b1 && clkd === 1'b0 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (pc !== e.pc) begin errors++; $display("FAIL commit_pc: got %h expected %h", pc, e.pc); end
        checks++;
        if (ovf !== e.ovf) begin errors++; $display("FAIL commit_ovf: got %b expected %b", ovf, e.ovf); end
        checks++;
        if (halted !== e.halt) begin errors++; $display("FAIL commit_halted: got %b expected %b", halted, e.halt); end
        checks++;
        if ({m, l} !== e.r[sel]) begin
          errors++; $display("FAIL commit_disp R%0d: got %h expected %h", sel, {m, l}, e.r[sel]);
        end
      end
      prev = clkd;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL commit_timeout: %0d pending after %0d cycles, expected 0", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic run_instr(input logic [7:0] x);
    exp_t e;
    ins = x;
    sel = sel + 2'd1;
    model_exec(x);
    e.pc = mpc; e.ovf = movf; e.halt = mhalt;
    for (int i = 0; i < 4; i++) e.r[i] = mr[i];
    sb.push_back(e);
    wait_drain();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; ins = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0; sel = 2'd0;
    model_reset();
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (clkd !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", clkd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      checks++;
      if ({m, l} !== 8'h00) begin errors++; $display("FAIL reset_reg R%0d: got %h expected 00", s, {m, l}); end
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (clkd !== ((k % 2) == 0)) begin
        errors++; $display("FAIL div1_toggle step %0d: got %b expected %b", k, clkd, (k % 2) == 0);
      end
    end
  endtask

  task automatic test_mem_init();
    logic [7:0] seq [4] = '{8'h73, 8'h74, 8'h79, 8'h7E};
    apply_reset();
    foreach (seq[i]) run_instr(seq[i]);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      checks++;
      if ({m, l} !== mr[s]) begin errors++; $display("FAIL mem_init R%0d: got %h expected %h", s, {m, l}, mr[s]); end
    end
  endtask

  task automatic test_program();
    logic [7:0] prog [6] = '{8'h71, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hFA};
    apply_reset();
    foreach (prog[i]) run_instr(prog[i]);
    run_instr(prog[mpc % 8'd6]);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      checks++;
      if ({m, l} !== mr[s]) begin errors++; $display("FAIL program R%0d: got %h expected %h", s, {m, l}, mr[s]); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    run_instr(8'h41);
    repeat (6) run_instr(8'h00);
    run_instr(8'h09);
    run_instr(8'h06);
    run_instr(8'h2F);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    apply_reset();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b expected 0", ovf); end
  endtask

  task automatic test_halt();
    apply_reset();
    run_instr(8'h45);
    repeat (6) run_instr(8'hC0);
    run_instr(8'hFF);
    run_instr(8'h84);
    run_instr(8'h00);
    run_instr(8'h41);
    run_instr(8'hC0);
    run_instr(8'h84);
    checks++; if (pc !== 8'h07) begin errors++; $display("FAIL halt_pc: got %h expected 07", pc); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_a.dmem[i] !== mm[i]) begin
        errors++; $display("FAIL halt_mem M%0d: got %h expected %h", i, dut_a.dmem[i], mm[i]);
      end
    end
    apply_reset();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL halt_reset_pc: got %h expected 00", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_flag: got %b expected 0", halted); end
  endtask

  task automatic test_xjump();
    apply_reset();
    ins = 8'b11xx_xx10;
    repeat (2) @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL xjump_halted: got %b expected 0", halted); end
    ins = 8'h00;
  endtask

  task automatic wait_b_edge(input logic want_fall, output int cyc);
    logic prev = clkd3;
    cyc = 0;
    forever begin
      @(negedge clk); cyc++;
      if (want_fall ? (prev === 1'b1 && clkd3 === 1'b0) : (prev === 1'b0 && clkd3 === 1'b1)) break;
      if (cyc >= 50) begin
        checks++; errors++;
        $display("FAIL div3_edge_timeout: no edge in %0d cycles, expected one within 50", cyc);
        break;
      end
      prev = clkd3;
    end
  endtask

  task automatic test_div3();
    int cyc, total, last, ncommit;
    logic prev;
    @(negedge clk);
    rst3 = 1'b1; ins3 = 8'h00; sel3 = 2'd0;
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    prev = clkd3; total = 0; last = -1; ncommit = 0;
    while (ncommit < 10 && total < 200) begin
      @(negedge clk); total++;
      if (prev === 1'b1 && clkd3 === 1'b0) begin
        ncommit++;
        checks++;
        if (pc3 !== 3'(ncommit)) begin errors++; $display("FAIL div3_pc commit %0d: got %0d expected %0d", ncommit, pc3, 3'(ncommit)); end
        if (last >= 0) begin
          checks++;
          if (total - last != 6) begin errors++; $display("FAIL div3_period: got %0d expected 6", total - last); end
        end
        last = total;
      end
      prev = clkd3;
    end
    if (ncommit < 10) begin
      checks++; errors++; $display("FAIL div3_commits: got %0d expected 10", ncommit);
    end
    ins3 = 8'h41;
    wait_b_edge(1'b1, cyc);
    checks++; if (pc3 !== 3'd3) begin errors++; $display("FAIL div3_lw_pc: got %0d expected 3", pc3); end
    checks++; if ({m3, l3} !== 8'h01) begin errors++; $display("FAIL div3_lw_r0: got %h expected 01", {m3, l3}); end
    ins3 = 8'h00;
    wait_b_edge(1'b0, cyc);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    checks++; if (pc3 !== 3'd0) begin errors++; $display("FAIL midreset_pc: got %0d expected 0", pc3); end
    checks++; if ({m3, l3} !== 8'h00) begin errors++; $display("FAIL midreset_r0: got %h expected 00", {m3, l3}); end
    ins3 = 8'h41;
    wait_b_edge(1'b1, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL midreset_latency: got %0d expected 6", cyc); end
    checks++; if (pc3 !== 3'd1) begin errors++; $display("FAIL midreset_next_pc: got %0d expected 1", pc3); end
    checks++; if ({m3, l3} !== 8'h01) begin errors++; $display("FAIL midreset_next_r0: got %h expected 01", {m3, l3}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork monitor(); join_none
    test_reset();
    test_mem_init();
    test_program();
    test_overflow();
    test_halt();
    test_xjump();
    test_div3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
